// File: rtl/iram_program_loader.sv
// IRAM program loader: streams words into the core IRAM, then runs the core.
// Define LOADER_READBACK_EN to verify every written word through iram_rdata.
module iram_program_loader #(
  parameter int IRAM_DEPTH    = 16,
  parameter int RUN_W         = 16,
  parameter int RELEASE_DELAY = 2,
  localparam int SEL_W        = $clog2(IRAM_DEPTH),
  localparam int CNT_W        = SEL_W + 1,
  localparam int RD_W         = $clog2(RELEASE_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             iram_we,
  output logic [SEL_W-1:0] iram_sel,
  output logic [31:0]      iram_wdata,
  input  logic [31:0]      iram_rdata,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] load_count,
  output logic             trunc,
  output logic             verify_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] budget_q, budget_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RD_W-1:0]  rel_q, rel_d;
  logic             done_q, done_d;
  logic             trunc_q, trunc_d;
  logic             hs;

`ifdef LOADER_READBACK_EN
  logic chk_q, chk_d;
  logic verr_q, verr_d;
  logic mismatch, pending;

  // No accept during a write pulse, so sel is stable for the next-cycle compare
  assign in_ready   = (state_q == S_LOAD) && !we_q;
  assign mismatch   = chk_q && (iram_rdata != wdata_q);
  assign pending    = we_q || chk_q;
  assign verify_err = verr_q;
`else
  logic unused_rdata;

  assign unused_rdata = ^iram_rdata;
  assign in_ready     = (state_q == S_LOAD);
  assign verify_err   = 1'b0;
`endif

  assign hs         = in_valid && in_ready;
  assign iram_we    = we_q;
  assign iram_sel   = sel_q;
  assign iram_wdata = wdata_q;
  assign core_rst_n = (state_q == S_RUN);
  assign busy       = (state_q == S_LOAD) ||
                      (state_q == S_RELEASE) ||
                      (state_q == S_RUN);
  assign done       = done_q;
  assign load_count = cnt_q;
  assign trunc      = trunc_q;

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    budget_d = budget_q;
    run_d    = run_q;
    rel_d    = rel_q;
    done_d   = done_q;
    trunc_d  = trunc_q;
`ifdef LOADER_READBACK_EN
    chk_d    = 1'b0;
    verr_d   = verr_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
`ifdef LOADER_READBACK_EN
      chk_d = we_q;
`endif
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_LOAD;
            done_d   = 1'b0;
            trunc_d  = 1'b0;
            cnt_d    = '0;
            budget_d = run_cycles;
`ifdef LOADER_READBACK_EN
            verr_d   = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          rel_d = '0;
          if (hs) begin
            we_d    = 1'b1;
            sel_d   = cnt_q[SEL_W-1:0];
            wdata_d = in_data;
            cnt_d   = cnt_q + CNT_W'(1);
            if (in_last) begin
              state_d = S_RELEASE;
            end else if (cnt_q == CNT_W'(IRAM_DEPTH - 1)) begin
              state_d = S_RELEASE;
              trunc_d = 1'b1;
            end
          end
        end
        S_RELEASE: begin
`ifdef LOADER_READBACK_EN
          if (!pending)
`endif
          begin
            if (rel_q == RD_W'(RELEASE_DELAY - 1)) begin
              state_d = S_RUN;
              run_d   = budget_q;
            end else begin
              rel_d = rel_q + RD_W'(1);
            end
          end
        end
        S_RUN: begin
          // A zero budget free-runs until abort
          if (budget_q != '0) begin
            run_d = run_q - RUN_W'(1);
            if (run_q == RUN_W'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
`ifdef LOADER_READBACK_EN
      if (mismatch && ((state_q == S_LOAD) || (state_q == S_RELEASE))) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        verr_d  = 1'b1;
        we_d    = 1'b0;
        chk_d   = 1'b0;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      sel_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      budget_q <= '0;
      run_q    <= '0;
      rel_q    <= '0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      budget_q <= budget_d;
      run_q    <= run_d;
      rel_q    <= rel_d;
      done_q   <= done_d;
      trunc_q  <= trunc_d;
    end
  end

`ifdef LOADER_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q  <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      chk_q  <= chk_d;
      verr_q <= verr_d;
    end
  end
`endif

endmodule

// File: tb/tb_iram_program_loader.sv
// Directed bench for iram_program_loader with a small IRAM model.
// Readback scenario runs only when LOADER_READBACK_EN is defined.
module tb_iram_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        iram_we;
  logic [3:0]  iram_sel;
  logic [31:0] iram_wdata;
  logic [31:0] iram_rdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic [4:0]  load_count;
  logic        trunc;
  logic        verify_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [16];
  bit          bad_en = 1'b0;
  int          wr_cnt = 0;
  int          hi_cnt = 0;
  logic [3:0]  wr_sel [64];
  logic [31:0] wr_dat [64];

`ifdef LOADER_READBACK_EN
  localparam int REL_CYC = 4;
`else
  localparam int REL_CYC = 2;
`endif

  iram_program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .iram_we    (iram_we),
    .iram_sel   (iram_sel),
    .iram_wdata (iram_wdata),
    .iram_rdata (iram_rdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .load_count (load_count),
    .trunc      (trunc),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  // Core IRAM model with an optional corrupted read of slot 1
  always @(posedge clk) begin
    if (iram_we) mem[iram_sel] <= iram_wdata;
  end
  assign iram_rdata = (bad_en && iram_sel == 4'd1) ? 32'hDEADBEEF
                                                   : mem[iram_sel];

  always @(negedge clk) begin
    if (iram_we) begin
      if (wr_cnt < 64) begin
        wr_sel[wr_cnt] = iram_sel;
        wr_dat[wr_cnt] = iram_wdata;
      end
      wr_cnt++;
    end
    if (core_rst_n) hi_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] rc);
    start      = 1'b1;
    run_cycles = rc;
    tick();
    start      = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  logic [31:0] prog [3];
  logic [31:0] w;
  int b, h, n, stall;
  bit ok;

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00108113;
    prog[2] = 32'h002081B3;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", iram_we, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", iram_sel, 0);
    check("rst_wdata", iram_wdata, 0);
    check("rst_count", load_count, 0);
    check("rst_trunc", trunc, 0);
    check("rst_verr", verify_err, 0);

    // Three-word program, budget 10
    b = wr_cnt;
    pulse_start(16'd10);
    check("t2_in_ready", in_ready, 1);
    check("t2_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      send(prog[i], i == 2, ok);
      check("t2_accept", ok, 1);
    end
    for (int i = 0; i < REL_CYC; i++) begin
      check("t2_rel_hold", core_rst_n, 0);
      tick();
    end
    h = hi_cnt;
    check("t2_released", core_rst_n, 1);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("t2_done", done, 1);
    check("t2_run_len", hi_cnt - h, 10);
    check("t2_core_held", core_rst_n, 0);
    check("t2_busy_off", busy, 0);
    check("t2_count", load_count, 3);
    check("t2_writes", wr_cnt - b, 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_sel", wr_sel[b+i], i);
      check("t2_data", wr_dat[b+i], prog[i]);
    end

    // 17 words without in_last: truncation at 16
    b = wr_cnt;
    pulse_start(16'd3);
    check("t3_done_clr", done, 0);
    for (int i = 0; i < 16; i++) begin
      send(32'h1000 + i, 1'b0, ok);
      check("t3_accept", ok, 1);
    end
    check("t3_trunc", trunc, 1);
    check("t3_count", load_count, 16);
    check("t3_ready_off", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h0000_1010;
    stall = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) stall++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_stall", stall, 0);
    check("t3_done", done, 1);
    check("t3_trunc_keep", trunc, 1);
    check("t3_writes", wr_cnt - b, 16);
    for (int i = 0; i < 16; i++) begin
      check("t3_sel", wr_sel[b+i], i);
      check("t3_data", wr_dat[b+i], 32'h1000 + i);
    end

    // Gapped valid, then abort in RUN
    b = wr_cnt;
    pulse_start(16'd100);
    check("t4_trunc_clr", trunc, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      tick();
      send(32'hA000_0000 + 32'(i * 3), i == 3, ok);
      check("t4_accept", ok, 1);
    end
    n = 0;
    while (!core_rst_n && n < 20) begin
      tick();
      n++;
    end
    check("t4_released", core_rst_n, 1);
    tick();
    tick();
    pulse_abort();
    check("t4_abort_rst", core_rst_n, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_ready", in_ready, 0);
    check("t4_abort_done", done, 0);
    check("t4_count_keep", load_count, 4);
    check("t4_writes", wr_cnt - b, 4);
    for (int i = 0; i < 4; i++) begin
      check("t4_sel", wr_sel[b+i], i);
      check("t4_data", wr_dat[b+i], 32'hA000_0000 + 32'(i * 3));
    end

    // Free-run budget with an ignored start
    b = wr_cnt;
    pulse_start(16'd0);
    send(32'h0000_0013, 1'b1, ok);
    check("t5_accept", ok, 1);
    n = 0;
    while (!core_rst_n && n < 20) begin
      tick();
      n++;
    end
    h = hi_cnt;
    for (int i = 0; i < 1000; i++) begin
      start = (i == 500);
      run_cycles = 16'd5;
      tick();
    end
    start = 1'b0;
    check("t5_free_run", hi_cnt - h, 1000);
    check("t5_busy", busy, 1);
    check("t5_done", done, 0);
    check("t5_count", load_count, 1);
    check("t5_writes", wr_cnt - b, 1);
    pulse_abort();
    check("t5_abort_rst", core_rst_n, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_verr", verify_err, 0);

`ifdef LOADER_READBACK_EN
    // Corrupted readback on the second word
    b = wr_cnt;
    h = hi_cnt;
    bad_en = 1'b1;
    pulse_start(16'd5);
    for (int i = 0; i < 3; i++) begin
      w = 32'h5000 + i;
      send(w, i == 2, ok);
    end
    for (int i = 0; i < 20; i++) tick();
    check("t6_verr", verify_err, 1);
    check("t6_done", done, 1);
    check("t6_never_run", hi_cnt - h, 0);
    check("t6_ready_off", in_ready, 0);
    check("t6_writes", wr_cnt - b, 2);
    bad_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
